cbd_sampler: RTL and testbench

Centered-binomial sampler that consumes the PRF bit string produced by the SHAKE-256 PRF stage (1536 bits for η1 = 3, 1024 bits for η2 = 2) and emits the 256 coefficients of one noise polynomial as a valid/ready stream. It sits directly downstream of the PRF and upstream of the NTT / polynomial buffer in key generation and encryption. The PRF output is captured once per polynomial, so the PRF may start its next squeeze while sampling proceeds.

---
 rtl/cbd_sampler.sv | 141 ++++++++++++++
 tb/tb_cbd_sampler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// Centered-binomial noise sampler: latches one PRF block and streams N_COEF coefficients mod Q.
// Macro CBD_ETA3_EN enables eta = 3 (n_num = 1); without it only eta = 2 is accepted.
//
// state  | meaning
// S_IDLE | waiting for a valid start
// S_RUN  | coefficient at coef_idx is valid, advances on coef_ready
// S_DONE | one-cycle done pulse, then back to S_IDLE
module cbd_sampler #(
  parameter int Q      = 3329,
  parameter int N_COEF = 256,
  parameter int B_SIZE = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:B_SIZE-1] B,
  input  logic              start,
  input  logic [1:0]        n_num,
  input  logic              coef_ready,
  output logic              coef_valid,
  output logic [11:0]       coef,
  output logic [7:0]        coef_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

`ifdef CBD_ETA3_EN
  localparam int BW = B_SIZE;
`else
  localparam int BW = 1024;
`endif

  localparam logic [11:0] Q_L    = 12'(Q);
  localparam logic [7:0]  IDX_LAST = 8'(N_COEF - 1);

  state_t          state_q;
  logic [0:BW-1]   b_q;
  logic [7:0]      idx_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            start_ok;
  logic [2:0]      a_sum;
  logic [2:0]      b_sum;
  logic [2:0]      mag;
  logic [11:0]     coef_val;

`ifdef CBD_ETA3_EN
  logic eta3_q;
  assign start_ok = start && ((n_num == 2'd1) || (n_num == 2'd2));
`else
  logic unused_b;
  assign unused_b = ^B[BW:B_SIZE-1];
  assign start_ok = start && (n_num == 2'd2);
`endif

  // b_q is shifted by 2*eta per transfer, so the current coefficient always sits at b_q[0:2*eta-1].
  always_comb begin
    a_sum = '0;
    b_sum = '0;
`ifdef CBD_ETA3_EN
    if (eta3_q) begin
      a_sum = {2'b0, b_q[0]} + {2'b0, b_q[1]} + {2'b0, b_q[2]};
      b_sum = {2'b0, b_q[3]} + {2'b0, b_q[4]} + {2'b0, b_q[5]};
    end else begin
      a_sum = {2'b0, b_q[0]} + {2'b0, b_q[1]};
      b_sum = {2'b0, b_q[2]} + {2'b0, b_q[3]};
    end
`else
    a_sum = {2'b0, b_q[0]} + {2'b0, b_q[1]};
    b_sum = {2'b0, b_q[2]} + {2'b0, b_q[3]};
`endif
    mag      = (a_sum >= b_sum) ? (a_sum - b_sum) : (b_sum - a_sum);
    coef_val = (a_sum >= b_sum) ? {9'd0, mag} : (Q_L - {9'd0, mag});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CBD_ETA3_EN
      eta3_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            b_q     <= B[0:BW-1];
`ifdef CBD_ETA3_EN
            eta3_q  <= (n_num == 2'd1);
`endif
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (coef_ready) begin
            if (idx_q == IDX_LAST) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + 8'd1;
`ifdef CBD_ETA3_EN
              b_q   <= eta3_q ? (b_q << 6) : (b_q << 4);
`else
              b_q   <= b_q << 4;
`endif
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign coef_valid = valid_q;
  assign coef       = valid_q ? coef_val : 12'd0;
  assign coef_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: expected coefficients come from a bit-level model into a scoreboard queue.
module tb_cbd_sampler;
  localparam int Q = 3329;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:1535] b_in;
  logic          start;
  logic [1:0]    n_num;
  logic          coef_ready;
  logic          coef_valid;
  logic [11:0]   coef;
  logic [7:0]    coef_idx;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  cbd_sampler dut (
    .clk(clk), .rst(rst), .B(b_in), .start(start), .n_num(n_num),
    .coef_ready(coef_ready), .coef_valid(coef_valid), .coef(coef),
    .coef_idx(coef_idx), .busy(busy), .done(done)
  );

  function automatic logic [11:0] model(input logic [0:1535] b, input int eta, input int i);
    int a = 0;
    int c = 0;
    int x;
    for (int j = 0; j < eta; j++) begin
      a += int'(b[2*i*eta + j]);
      c += int'(b[2*i*eta + eta + j]);
    end
    x = a - c;
    return (x >= 0) ? 12'(x) : 12'(Q + x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] nn, input int eta);
    sb.delete();
    for (int i = 0; i < 256; i++) sb.push_back({8'(i), model(b_in, eta, i)});
    n_num = nn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_b();
    for (int k = 0; k < 48; k++) b_in[k*32 +: 32] = $urandom();
  endtask

  // Drains the scoreboard; optional backpressure, ignored start and mid-run reset by coefficient index.
  task automatic consume(input string tag, input int bp_at, input int bp_len,
                         input int ign_at, input int rst_at, input int exp_cyc);
    int   cyc = 0;
    int   held = 0;
    bit   aborted = 0;
    logic [19:0] e;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (sb.size() > 0 && cyc < 2000) begin
      if (rst_at >= 0 && coef_idx == 8'(rst_at)) begin
        rst = 1'b0;
        #1;
        chk({tag, "_rst_outs"}, {9'd0, coef_valid, coef, coef_idx, busy, done}, 32'd0);
        sb.delete();
        aborted = 1;
        break;
      end
      chk({tag, "_valid"}, {31'd0, coef_valid}, 32'd1);
      if (ign_at >= 0 && coef_idx == 8'(ign_at)) begin
        b_in  = ~b_in;
        n_num = 2'd2;
        start = 1'b1;
      end
      if (bp_at >= 0 && coef_idx == 8'(bp_at) && held < bp_len) begin
        chk({tag, "_hold"}, {12'd0, coef_idx, coef}, {12'd0, sb[0]});
        held++;
        coef_ready = 1'b0;
      end else begin
        coef_ready = 1'b1;
        e = sb.pop_front();
        chk({tag, "_coef"}, {12'd0, coef_idx, coef}, {12'd0, e});
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (!aborted) begin
      chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_done_pulse"}, {30'd0, done, coef_valid}, 32'd2);
      @(negedge clk);
      chk({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; coef_ready = 1'b0; n_num = 2'd2; b_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {9'd0, coef_valid, coef, coef_idx, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    b_in = '0;
    do_start(2'd2, 2);
    consume("zero2", -1, 0, -1, -1, 256);

    rand_b();
    b_in[0:7] = 8'b1100_0011;
    do_start(2'd2, 2);
    chk("pat_c0", {20'd0, coef}, 32'd2);
    consume("pat2", -1, 0, -1, -1, 256);

    rand_b();
    do_start(2'd2, 2);
    consume("bp", 10, 5, -1, -1, 261);

    rand_b();
    do_start(2'd2, 2);
    consume("ignstart", -1, 0, 100, -1, 256);

    n_num = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("inv_n3", {30'd0, busy, coef_valid}, 32'd0);
    n_num = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("inv_n0", {30'd0, busy, coef_valid}, 32'd0);

`ifdef CBD_ETA3_EN
    b_in = '1;
    do_start(2'd1, 3);
    consume("ones3", -1, 0, -1, -1, 256);
    b_in = '0;
    b_in[0:5] = 6'b111000;
    do_start(2'd1, 3);
    chk("eta3_pos", {20'd0, coef}, 32'd3);
    consume("pos3", -1, 0, -1, -1, 256);
    b_in[0:5] = 6'b000111;
    do_start(2'd1, 3);
    chk("eta3_neg", {20'd0, coef}, 32'd3326);
    consume("neg3", 20, 3, -1, -1, 259);
`else
    b_in = '1;
    n_num = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("eta3_off", {30'd0, busy, coef_valid}, 32'd0);
`endif

    rand_b();
    do_start(2'd2, 2);
    consume("rst_mid", -1, 0, -1, 50, 0);
    @(negedge clk);
    chk("rst_held", {30'd0, busy, coef_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rand_b();
    do_start(2'd2, 2);
    chk("fresh_idx", {24'd0, coef_idx}, 32'd0);
    consume("fresh", -1, 0, -1, -1, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
